// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary-to-BCD converter, one input bit per clock
// Optional build macro: BIN2BCD_SATURATE_EN clamps bcd_int to 16'h9999 when the value exceeds 9999.
module bin2bcd_seq #(
  parameter int BIN_W = 14
) (
  input  logic             fpga_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [15:0]      bcd_int
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_hold;
  logic [BIN_W-1:0] bin_sr;
  logic [19:0]      scratch;
  logic [19:0]      scratch_adj;
  logic [CNT_W-1:0] cnt;
  logic             ovf_next;

  // Add-3 correction on every scratch digit before it is doubled by the shift.
  always_comb begin
    scratch_adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5) begin
        scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
    end
  end

  // Overflow judged on the captured value, so a wandering bin_in cannot affect it.
  assign ovf_next = 32'(bin_hold) > 32'd9999;

  always_ff @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      bcd_int  <= 16'h0000;
      bin_hold <= '0;
      bin_sr   <= '0;
      scratch  <= '0;
      cnt      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_hold <= bin_in;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end
        LOAD: begin
          bin_sr  <= bin_hold;
          scratch <= '0;
          cnt     <= CNT_W'(BIN_W);
          state   <= SHIFT;
        end
        SHIFT: begin
          {scratch, bin_sr} <= {scratch_adj, bin_sr} << 1;
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          ovf <= ovf_next;
`ifdef BIN2BCD_SATURATE_EN
          bcd_int <= ovf_next ? 16'h9999 : scratch[15:0];
`else
          bcd_int <= scratch[15:0];
`endif
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb/tb_bin2bcd_seq.sv - randomized self-checking bench for bin2bcd_seq against an arithmetic model
`timescale 1ns/1ps
module tb_bin2bcd_seq;

  localparam int BIN_W = 14;
  localparam int LAT   = BIN_W + 2;

  logic             fpga_clk  = 1'b0;
  logic             sys_rst_n = 1'b0;
  logic             start     = 1'b0;
  logic [BIN_W-1:0] bin_in    = '0;
  logic             busy;
  logic             done;
  logic             ovf;
  logic [15:0]      bcd_int;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  bin2bcd_seq #(.BIN_W(BIN_W)) dut (
    .fpga_clk  (fpga_clk),
    .sys_rst_n (sys_rst_n),
    .start     (start),
    .bin_in    (bin_in),
    .busy      (busy),
    .done      (done),
    .ovf       (ovf),
    .bcd_int   (bcd_int)
  );

  always #5 fpga_clk = ~fpga_clk;

  function automatic logic [15:0] ref_bcd(input int v);
    int m;
    m = v % 10000;
`ifdef BIN2BCD_SATURATE_EN
    if (v > 9999) return 16'h9999;
`endif
    return {4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a conversion occupies LAT edges after acceptance, result appears with done.
  int          m_phase = 0;
  int          m_cap   = 0;
  logic        m_busy  = 1'b0;
  logic        m_done  = 1'b0;
  logic        m_ovf   = 1'b0;
  logic [15:0] m_bcd   = 16'h0000;

  always @(posedge fpga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_phase <= 0;
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_ovf   <= 1'b0;
      m_bcd   <= 16'h0000;
    end else begin
      m_done <= 1'b0;
      if (m_phase == 0) begin
        if (start) begin
          m_phase <= 1;
          m_cap   <= int'(bin_in);
          m_busy  <= 1'b1;
        end
      end else if (m_phase == LAT) begin
        m_phase <= 0;
        m_busy  <= 1'b0;
        m_done  <= 1'b1;
        m_ovf   <= (m_cap > 9999);
        m_bcd   <= ref_bcd(m_cap);
      end else begin
        m_phase <= m_phase + 1;
      end
    end
  end

  always @(posedge fpga_clk) begin
    #1;
    if (chk_en) begin
      check("done", 32'(done), 32'(m_done));
      check("busy", 32'(busy), 32'(m_busy));
      check("ovf", 32'(ovf), 32'(m_ovf));
      check("bcd_int", 32'(bcd_int), 32'(m_bcd));
    end
  end

  task automatic convert(input int v, output int lat);
    start  = 1'b1;
    bin_in = BIN_W'(v);
    lat    = -1;
    for (int i = 0; i < 40; i++) begin
      @(posedge fpga_clk); #1;
      lat++;
      if (i == 0) begin
        start  = 1'b0;
        bin_in = BIN_W'($urandom);
      end
      if (done) break;
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge fpga_clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit ok;
    int ndone;
    int v;

    repeat (3) @(posedge fpga_clk);
    #1;
    sys_rst_n = 1'b1;
    chk_en    = 1'b1;
    @(posedge fpga_clk); #1;
    check("rst_bcd", 32'(bcd_int), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);

    convert(1234, lat);
    check("lat_1234", 32'(lat), 32'(LAT));
    check("bcd_1234", 32'(bcd_int), 32'h1234);
    check("ovf_1234", 32'(ovf), 32'h0);
    convert(0, lat);
    check("bcd_0", 32'(bcd_int), 32'h0000);
    convert(9999, lat);
    check("lat_9999", 32'(lat), 32'(LAT));
    check("bcd_9999", 32'(bcd_int), 32'h9999);
    check("ovf_9999", 32'(ovf), 32'h0);

    convert(12345, lat);
    check("ovf_12345", 32'(ovf), 32'h1);
`ifdef BIN2BCD_SATURATE_EN
    check("bcd_12345", 32'(bcd_int), 32'h9999);
`else
    check("bcd_12345", 32'(bcd_int), 32'h2345);
`endif

    start  = 1'b1;
    bin_in = BIN_W'(42);
    @(posedge fpga_clk); #1;
    start  = 1'b0;
    bin_in = '0;
    repeat (4) begin
      @(posedge fpga_clk); #1;
    end
    start  = 1'b1;
    bin_in = BIN_W'(777);
    @(posedge fpga_clk); #1;
    start  = 1'b0;
    ndone  = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge fpga_clk); #1;
      if (done) begin
        ndone++;
        if (ndone == 1) check("bcd_42", 32'(bcd_int), 32'h0042);
      end
    end
    check("single_done", 32'(ndone), 32'h1);
    convert(777, lat);
    check("bcd_777", 32'(bcd_int), 32'h0777);

    start  = 1'b1;
    bin_in = '0;
    for (int i = 0; i <= 20; i++) begin
      wait_done(ok);
      check("b2b_done", 32'(ok), 32'h1);
      check("b2b_val", 32'(bcd_int), 32'(ref_bcd(i)));
      bin_in = BIN_W'(i + 1);
    end
    start = 1'b0;
    check("b2b_last", 32'(bcd_int), 32'h0020);

    convert(500, lat);
    check("bcd_500", 32'(bcd_int), 32'h0500);
    start  = 1'b1;
    bin_in = BIN_W'($urandom_range(1, 9999));
    @(posedge fpga_clk); #1;
    start = 1'b0;
    repeat (6) begin
      @(posedge fpga_clk); #1;
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("abort_bcd", 32'(bcd_int), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_done", 32'(done), 32'h0);
    repeat (2) begin
      @(posedge fpga_clk); #1;
    end
    sys_rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge fpga_clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'h0);
    v = int'($urandom_range(0, 16383));
    convert(v, lat);
    check("post_abort_lat", 32'(lat), 32'(LAT));
    check("post_abort_bcd", 32'(bcd_int), 32'(ref_bcd(v)));

    ndone = 0;
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bin_in = BIN_W'($urandom_range(9990, 10010));
      else                           bin_in = BIN_W'($urandom_range(0, 16383));
      @(posedge fpga_clk); #1;
      if (done) ndone++;
    end
    start = 1'b0;
    repeat (20) begin
      @(posedge fpga_clk); #1;
    end
    check("random_progress", 32'(ndone > 50), 32'h1);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
